// File: rtl/relu_grad_gate.sv
// ReLU backward gate: captures the forward sign mask of one frame, then passes or
// zeroes each incoming gradient according to that mask, with a one-deep output register.
module relu_grad_gate #(
  parameter int FEATURE_WIDTH = 32,
  parameter int DEPTH         = 64,
  parameter int ADDR_WIDTH    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fwd_valid,
  input  logic [FEATURE_WIDTH-1:0] fwd_in,
  input  logic                     fwd_last,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic [FEATURE_WIDTH-1:0] grad_in,
  output logic                     grad_out_valid,
  input  logic                     grad_out_ready,
  output logic [FEATURE_WIDTH-1:0] grad_out,
  output logic                     grad_out_last,
  output logic                     busy,
  output logic                     overflow,
  output logic [ADDR_WIDTH:0]      mask_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    BACKWARD = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t                   r_state;
  logic [DEPTH-1:0]         r_mask;
  logic [ADDR_WIDTH-1:0]    r_wr_ptr;
  logic [ADDR_WIDTH-1:0]    r_rd_ptr;
  logic [ADDR_WIDTH:0]      r_mask_count;
  logic                     r_overflow;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [FEATURE_WIDTH-1:0] r_out_data;

  logic                     w_full;
  logic                     w_mask_we;
  logic                     w_accept;
  logic                     w_rd_last;
  logic [FEATURE_WIDTH-1:0] w_gated;

  assign w_full    = (r_mask_count == (ADDR_WIDTH+1)'(DEPTH));
  // IDLE always writes entry 0; wr_ptr is already 0 there, so one write port suffices.
  assign w_mask_we = fwd_valid && ((r_state == IDLE) || ((r_state == CAPTURE) && !w_full));
  assign w_accept  = grad_valid && grad_ready;
  assign w_rd_last = ({1'b0, r_rd_ptr} == (r_mask_count - (ADDR_WIDTH+1)'(1)));
  assign w_gated   = r_mask[r_rd_ptr] ? grad_in : {FEATURE_WIDTH{1'b0}};

  assign grad_ready     = (r_state == BACKWARD) && (!r_out_valid || grad_out_ready);
  assign grad_out_valid = r_out_valid;
  assign grad_out       = r_out_data;
  assign grad_out_last  = r_out_last;
  assign busy           = (r_state != IDLE);
  assign overflow       = r_overflow;
  assign mask_count     = r_mask_count;

  // Mask storage carries no reset: only entries below mask_count are ever read.
  always_ff @(posedge clk) begin
    if (w_mask_we) begin
      r_mask[r_wr_ptr] <= ~fwd_in[FEATURE_WIDTH-1];
    end
  end

  // Frame sequencing, pointers and the registered gradient output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_ptr     <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr     <= {ADDR_WIDTH{1'b0}};
      r_mask_count <= {(ADDR_WIDTH+1){1'b0}};
      r_overflow   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= {FEATURE_WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (fwd_valid) begin
            r_wr_ptr     <= ADDR_WIDTH'(1);
            r_mask_count <= (ADDR_WIDTH+1)'(1);
            r_state      <= fwd_last ? BACKWARD : CAPTURE;
          end
        end
        CAPTURE: begin
          if (fwd_valid) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
              r_mask_count <= r_mask_count + (ADDR_WIDTH+1)'(1);
            end
            if (fwd_last) begin
              r_state <= BACKWARD;
            end
          end
        end
        BACKWARD: begin
          if (w_accept) begin
            r_out_data  <= w_gated;
            r_out_valid <= 1'b1;
            r_out_last  <= w_rd_last;
            r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(1);
            if (w_rd_last) begin
              r_state <= DRAIN;
            end
          end else if (grad_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          // Only the final entry can be pending here; its handshake closes the frame.
          if (r_out_valid && grad_out_ready && r_out_last) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_wr_ptr     <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr     <= {ADDR_WIDTH{1'b0}};
            r_mask_count <= {(ADDR_WIDTH+1){1'b0}};
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_grad_gate.sv
// Self-checking bench for relu_grad_gate (FEATURE_WIDTH=32, DEPTH=4): directed frames
// plus randomized frames and handshakes checked against a frame-level reference model.
module tb_relu_grad_gate;

  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fwd_valid = 1'b0;
  logic [FW-1:0] fwd_in = '0;
  logic          fwd_last = 1'b0;
  logic          grad_valid = 1'b0;
  logic          grad_ready;
  logic [FW-1:0] grad_in = '0;
  logic          grad_out_valid;
  logic          grad_out_ready = 1'b0;
  logic [FW-1:0] grad_out;
  logic          grad_out_last;
  logic          busy;
  logic          overflow;
  logic [AW:0]   mask_count;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [FW-1:0] fvals[8];
  logic          ovf_model = 1'b0;

  relu_grad_gate #(.FEATURE_WIDTH(FW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_last(fwd_last),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .grad_out_valid(grad_out_valid), .grad_out_ready(grad_out_ready),
    .grad_out(grad_out), .grad_out_last(grad_out_last),
    .busy(busy), .overflow(overflow), .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  // Stimulus only: plays fvals[0..n-1] as one forward frame, optionally with idle gaps.
  task automatic drive_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        fwd_valid = 1'b0; fwd_last = 1'b0;
        @(negedge clk);
      end
      fwd_valid = 1'b1; fwd_in = fvals[i]; fwd_last = (i == n - 1);
      @(negedge clk);
    end
    fwd_valid = 1'b0; fwd_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grad_out_valid, grad_out_last, grad_ready, busy, overflow, mask_count, grad_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b l=%b r=%b busy=%b ovf=%b cnt=%0d out=%h, want all zero",
               grad_out_valid, grad_out_last, grad_ready, busy, overflow, mask_count, grad_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [FW-1:0] exp_out[4];
    exp_out[0] = 32'd10; exp_out[1] = 32'd0; exp_out[2] = 32'd30; exp_out[3] = 32'd0;
    fvals[0] = 32'h0000_0005; fvals[1] = 32'hFFFF_FFFE; fvals[2] = 32'h0000_0000; fvals[3] = 32'h8000_0000;
    drive_frame(4, 1'b0);
    n_checks++;
    if (mask_count !== 3'd4 || busy !== 1'b1 || grad_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_capture: cnt=%0d busy=%b ready=%b, want 4 1 1", mask_count, busy, grad_ready);
    end
    grad_valid = 1'b1; grad_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grad_in = 32'd10 * (i + 1);
      @(negedge clk);
      n_checks++;
      if (grad_out !== exp_out[i] || grad_out_valid !== 1'b1 || grad_out_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got %0d v=%b l=%b, want %0d v=1 l=%b",
                 i, grad_out, grad_out_valid, grad_out_last, exp_out[i], (i == 3));
      end
    end
    grad_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grad_out_valid !== 1'b0 || mask_count !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b v=%b cnt=%0d, want 0 0 0", busy, grad_out_valid, mask_count);
    end
  endtask

  task automatic test_single();
    fvals[0] = 32'h0000_0003;
    drive_frame(1, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || mask_count !== 3'd1 || grad_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_backward: busy=%b cnt=%0d ready=%b, want 1 1 1", busy, mask_count, grad_ready);
    end
    grad_valid = 1'b1; grad_in = 32'h7; grad_out_ready = 1'b1;
    @(negedge clk);
    grad_valid = 1'b0;
    n_checks++;
    if (grad_out !== 32'h7 || grad_out_valid !== 1'b1 || grad_out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL single_out: got %h v=%b l=%b, want 7 1 1", grad_out, grad_out_valid, grad_out_last);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_fwd_ignore();
    logic [FW-1:0] g0;
    fvals[0] = 32'h0000_0100; fvals[1] = 32'hFFFF_0000;
    drive_frame(2, 1'b0);
    g0 = $urandom;
    for (int c = 0; c < 3; c++) begin
      fwd_valid = 1'b1; fwd_in = $urandom; fwd_last = c[0];
      @(negedge clk);
      n_checks++;
      if (mask_count !== 3'd2 || grad_out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ignore_fwd[%0d]: cnt=%0d v=%b busy=%b, want 2 0 1", c, mask_count, grad_out_valid, busy);
      end
    end
    grad_out_ready = 1'b1; grad_valid = 1'b1; grad_in = g0;
    @(negedge clk);
    n_checks++;
    if (grad_out !== g0 || grad_out_last !== 1'b0 || mask_count !== 3'd2) begin
      n_fail++;
      $display("FAIL ignore_out0: got %h l=%b cnt=%0d, want %h 0 2", grad_out, grad_out_last, mask_count, g0);
    end
    grad_in = $urandom | 32'h1;
    @(negedge clk);
    grad_valid = 1'b0;
    n_checks++;
    if (grad_out !== 32'h0 || grad_out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_out1: got %h l=%b, want 0 1", grad_out, grad_out_last);
    end
    @(negedge clk);
    fwd_valid = 1'b0; fwd_last = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mask_count !== 3'd0) begin
      n_fail++;
      $display("FAIL ignore_idle: busy=%b cnt=%0d, want 0 0", busy, mask_count);
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] g[4];
    for (int i = 0; i < 4; i++) begin
      fvals[i] = $urandom_range(0, 32'h7FFF_FFFF);
      g[i] = $urandom;
    end
    drive_frame(4, 1'b0);
    grad_valid = 1'b1; grad_in = g[0]; grad_out_ready = 1'b1;
    @(negedge clk);
    grad_out_ready = 1'b0; grad_in = g[1];
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (grad_ready !== 1'b0 || grad_out_valid !== 1'b1 || grad_out !== g[0]) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ready=%b v=%b out=%h, want 0 1 %h", c, grad_ready, grad_out_valid, grad_out, g[0]);
      end
      @(negedge clk);
    end
    grad_out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      grad_in = g[i];
      @(negedge clk);
      n_checks++;
      if (grad_out !== g[i] || grad_out_valid !== 1'b1 || grad_out_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL bp_out[%0d]: got %h v=%b l=%b, want %h 1 %b", i, grad_out, grad_out_valid, grad_out_last, g[i], (i == 3));
      end
    end
    grad_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grad_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: busy=%b v=%b, want 0 0", busy, grad_out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] g[4];
    fvals[0] = 32'd1; fvals[1] = 32'hFFFF_FFFF; fvals[2] = 32'd7; fvals[3] = 32'd0; fvals[4] = 32'hFFFF_FFFB;
    drive_frame(5, 1'b0);
    ovf_model = 1'b1;
    n_checks++;
    if (overflow !== 1'b1 || mask_count !== 3'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_capture: ovf=%b cnt=%0d busy=%b, want 1 4 1", overflow, mask_count, busy);
    end
    grad_valid = 1'b1; grad_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g[i] = $urandom;
      grad_in = g[i];
      @(negedge clk);
      n_checks++;
      if (grad_out !== (($signed(fvals[i]) >= 0) ? g[i] : 32'd0) || grad_out_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL ovf_out[%0d]: got %h l=%b, want %h %b", i, grad_out, grad_out_last,
                 (($signed(fvals[i]) >= 0) ? g[i] : 32'd0), (i == 3));
      end
    end
    grad_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: busy=%b ovf=%b, want 0 1", busy, overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] g1;
    for (int i = 0; i < 4; i++) fvals[i] = 32'd5 + i;
    drive_frame(4, 1'b0);
    grad_valid = 1'b1; grad_out_ready = 1'b1;
    repeat (2) begin
      grad_in = $urandom;
      @(negedge clk);
    end
    grad_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grad_out_valid, grad_out_last, grad_ready, busy, overflow, mask_count, grad_out} !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: v=%b l=%b r=%b busy=%b ovf=%b cnt=%0d out=%h, want all zero",
               grad_out_valid, grad_out_last, grad_ready, busy, overflow, mask_count, grad_out);
    end
    ovf_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fvals[0] = 32'h8000_0001; fvals[1] = 32'h0000_0002;
    drive_frame(2, 1'b0);
    g1 = $urandom;
    grad_valid = 1'b1; grad_in = $urandom | 32'h1;
    @(negedge clk);
    n_checks++;
    if (grad_out !== 32'd0 || grad_out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idx0: got %h l=%b, want 0 0", grad_out, grad_out_last);
    end
    grad_in = g1;
    @(negedge clk);
    grad_valid = 1'b0;
    n_checks++;
    if (grad_out !== g1 || grad_out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_idx1: got %h l=%b, want %h 1", grad_out, grad_out_last, g1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int            n, exp_n, j, budget;
    logic [FW-1:0] exp_q[$];
    logic          last_q[$];
    for (int f = 0; f < 15; f++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) fvals[i] = $urandom;
      if (n > DEPTH) ovf_model = 1'b1;
      exp_n = (n > DEPTH) ? DEPTH : n;
      drive_frame(n, 1'b1);
      n_checks++;
      if (mask_count !== exp_n[AW:0] || overflow !== ovf_model) begin
        n_fail++;
        $display("FAIL rnd_capture[%0d]: cnt=%0d ovf=%b, want %0d %b", f, mask_count, overflow, exp_n, ovf_model);
      end
      j = 0; budget = 0;
      exp_q.delete(); last_q.delete();
      while ((j < exp_n || exp_q.size() > 0) && budget < 300) begin
        if (exp_q.size() > 0) begin
          n_checks++;
          if (grad_out_valid !== 1'b1 || grad_out !== exp_q[0] || grad_out_last !== last_q[0]) begin
            n_fail++;
            $display("FAIL rnd_out[%0d]: v=%b out=%h l=%b, want 1 %h %b", f, grad_out_valid, grad_out, grad_out_last, exp_q[0], last_q[0]);
          end
        end
        grad_valid = ($urandom_range(0, 3) != 0);
        grad_in = $urandom;
        grad_out_ready = ($urandom_range(0, 3) != 0);
        fwd_valid = ($urandom_range(0, 4) == 0);
        fwd_in = $urandom;
        #1;
        n_checks++;
        if (grad_ready !== (j < exp_n && (exp_q.size() == 0 || grad_out_ready))) begin
          n_fail++;
          $display("FAIL rnd_ready[%0d]: got %b at entry %0d", f, grad_ready, j);
        end
        if (grad_out_valid && grad_out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
        end
        if (grad_valid && grad_ready) begin
          exp_q.push_back(($signed(fvals[j]) >= 0) ? grad_in : 32'd0);
          last_q.push_back(j == exp_n - 1);
          j++;
        end
        @(negedge clk);
        budget++;
      end
      grad_valid = 1'b0; fwd_valid = 1'b0;
      n_checks++;
      if (budget >= 300 || busy !== 1'b0 || grad_out_valid !== 1'b0 || mask_count !== 3'd0) begin
        n_fail++;
        $display("FAIL rnd_end[%0d]: budget=%0d busy=%b v=%b cnt=%0d, want idle", f, budget, busy, grad_out_valid, mask_count);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_fwd_ignore();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_grad_gate.md
RELU_GRAD_GATE -- requirements
Module: relu_grad_gate

Interface
REQ-001 Parameter FEATURE_WIDTH, default 32: bit width of forward features and gradients (two's complement).
REQ-002 Parameter DEPTH, default 64: maximum features per capture frame (mask buffer entries).
REQ-003 Parameter ADDR_WIDTH, default 6: pointer width; DEPTH SHALL equal 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fwd_valid  input  1  forward pre-activation sample present this cycle (no backpressure).
REQ-007 fwd_in  input  FEATURE_WIDTH  forward pre-activation value.
REQ-008 fwd_last  input  1  marks final forward sample of frame; qualified by fwd_valid.
REQ-009 grad_valid  input  1  upstream gradient valid.
REQ-010 grad_ready  output  1  block accepts gradient this cycle.
REQ-011 grad_in  input  FEATURE_WIDTH  incoming gradient.
REQ-012 grad_out_valid  output  1  gated gradient valid.
REQ-013 grad_out_ready  input  1  downstream accepts gated gradient.
REQ-014 grad_out  output  FEATURE_WIDTH  gated gradient.
REQ-015 grad_out_last  output  1  marks gated gradient of final frame entry.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 overflow  output  1  sticky: a forward sample was dropped because the buffer was full.
REQ-018 mask_count  output  ADDR_WIDTH+1  number of mask bits captured in current frame.

Function
REQ-019 States SHALL be IDLE, CAPTURE, BACKWARD, DRAIN.
REQ-020 Mask bit for a sample SHALL be ~fwd_in[FEATURE_WIDTH-1] (1 = forward ReLU passed value, zero included).
REQ-021 IDLE: on fwd_valid, write mask[0], mask_count <= 1; go to BACKWARD if fwd_last else CAPTURE.
REQ-022 CAPTURE: each fwd_valid writes mask[wr_ptr], increments wr_ptr and mask_count; fwd_last moves to BACKWARD next cycle.
REQ-023 fwd_valid when mask_count == DEPTH: sample dropped, overflow <= 1, count unchanged; fwd_last on a dropped sample still ends capture.
REQ-024 fwd_valid SHALL be ignored in BACKWARD and DRAIN.
REQ-025 grad_ready SHALL be 1 only in BACKWARD and only when (!grad_out_valid || grad_out_ready); 0 in all other states.
REQ-026 On grad_valid && grad_ready: grad_out <= mask[rd_ptr] ? grad_in : 0, grad_out_valid <= 1, grad_out_last <= (rd_ptr == mask_count-1), rd_ptr++; latency exactly 1 cycle.
REQ-027 grad_out_valid SHALL hold, with grad_out and grad_out_last stable, until grad_out_ready; if ready and no new accept, grad_out_valid <= 0 next cycle.
REQ-028 Full throughput: with grad_valid and grad_out_ready continuously high, one gradient per cycle.
REQ-029 Accept of last entry moves BACKWARD to DRAIN; DRAIN returns to IDLE in the cycle after grad_out_valid && grad_out_ready with grad_out_last=1.
REQ-030 Entry to IDLE SHALL clear wr_ptr, rd_ptr, mask_count; overflow SHALL persist until reset.
REQ-031 Mask bits need no reset; only entries below mask_count are ever read.

Reset
REQ-032 Asserting rst_n low SHALL at any time, including mid-frame, force state IDLE, grad_out_valid 0, grad_out 0, grad_out_last 0, grad_ready 0, busy 0, overflow 0, mask_count 0, all pointers 0.
REQ-033 After rst_n deasserts, first fwd_valid SHALL start a new frame per REQ-021.

Verification (FEATURE_WIDTH=32, DEPTH=4)
REQ-034 Forward 0x00000005, 0xFFFFFFFE, 0x00000000, 0x80000000(last); gradients 10,20,30,40 with ready high -> grad_out 10,0,30,0 on consecutive cycles, last on 4th, mask_count 4, then IDLE.
REQ-035 Single sample fwd_in=0x00000003 with fwd_last -> BACKWARD next cycle; grad_in=0x7 -> grad_out 0x7 with grad_out_last=1.
REQ-036 Five forward samples, last on 5th -> overflow=1, mask_count=4, 4 gradients produced, last on 4th.
REQ-037 Backpressure: grad_out_ready low 3 cycles during BACKWARD -> grad_ready 0, grad_out stable, no gradient lost or duplicated.
REQ-038 rst_n pulsed low mid-BACKWARD after 2 of 4 gradients -> all outputs reset values immediately; next frame starts at mask index 0.
REQ-039 fwd_valid pulses during BACKWARD -> ignored; mask_count and gated outputs unchanged.
